// File: rtl/mem_rr_arbiter_if.sv
// rtl/mem_rr_arbiter_if.sv - client and memory bus bundle for the round-robin memory arbiter
// master is the arbiter side; slave is the client/memory side.
interface mem_rr_arbiter_if #(
    parameter int CLIENT_CNT = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
);
    localparam int GRANT_W = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;

    logic [CLIENT_CNT-1:0]        requests;
    logic [CLIENT_CNT*ADDR_W-1:0] addrs;
    logic [CLIENT_CNT-1:0]        wes;
    logic [CLIENT_CNT*DATA_W-1:0] data_outs;
    logic [DATA_W-1:0]            mem_rdata;
    logic [CLIENT_CNT-1:0]        readies;
    logic [DATA_W-1:0]            rdata;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         mem_we;
    logic                         mem_en;
    logic                         busy;
    logic [GRANT_W-1:0]           grant_id;

    modport master (
        input  requests, addrs, wes, data_outs, mem_rdata,
        output readies, rdata, mem_addr, mem_wdata, mem_we, mem_en, busy, grant_id
    );

    modport slave (
        output requests, addrs, wes, data_outs, mem_rdata,
        input  readies, rdata, mem_addr, mem_wdata, mem_we, mem_en, busy, grant_id
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter and access sequencer for the shared memory bus
// One client at a time: grant, present the access for WAIT_STATES+1 cycles, then hold ready until release.
module mem_rr_arbiter #(
    parameter int CLIENT_CNT  = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_rr_arbiter_if.master bus
);
    localparam int GW = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_d;
    logic [GW-1:0]         last_grant, last_grant_d;
    logic [GW-1:0]         grant_d;
    logic [3:0]            wait_cnt, wait_cnt_d;
    logic                  is_write, is_write_d;
    logic [CLIENT_CNT-1:0] readies_d;
    logic [DATA_W-1:0]     rdata_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_d;
    logic                  mem_we_d, mem_en_d, busy_d;
    logic                  pick_found;
    logic [GW-1:0]         pick_idx;

    function automatic logic [GW-1:0] wrap_idx(input int v);
        return GW'(v % CLIENT_CNT);
    endfunction

    // Search starts just after the last served client, so every requester is reached within CLIENT_CNT grants.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= CLIENT_CNT; k++) begin
            if (!pick_found && bus.requests[wrap_idx(int'(last_grant) + k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(int'(last_grant) + k);
            end
        end
    end

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        grant_d      = bus.grant_id;
        wait_cnt_d   = wait_cnt;
        is_write_d   = is_write;
        readies_d    = bus.readies;
        rdata_d      = bus.rdata;
        mem_addr_d   = bus.mem_addr;
        mem_wdata_d  = bus.mem_wdata;
        mem_we_d     = bus.mem_we;
        mem_en_d     = bus.mem_en;
        busy_d       = bus.busy;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    mem_addr_d  = bus.addrs[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.data_outs[int'(pick_idx)*DATA_W +: DATA_W];
                    mem_we_d    = bus.wes[pick_idx];
                    is_write_d  = bus.wes[pick_idx];
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    wait_cnt_d  = 4'(WAIT_STATES);
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_we_d = 1'b0;
                if (wait_cnt != 4'd0) begin
                    wait_cnt_d = wait_cnt - 4'd1;
                end else begin
                    if (!is_write) rdata_d = bus.mem_rdata;
                    readies_d[bus.grant_id] = 1'b1;
                    mem_en_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Release only once the client has seen ready and withdrawn its request.
                if (!bus.requests[bus.grant_id]) begin
                    readies_d    = '0;
                    busy_d       = 1'b0;
                    last_grant_d = bus.grant_id;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= GW'(CLIENT_CNT - 1);
            wait_cnt      <= '0;
            is_write      <= 1'b0;
            bus.grant_id  <= '0;
            bus.readies   <= '0;
            bus.rdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            last_grant    <= last_grant_d;
            wait_cnt      <= wait_cnt_d;
            is_write      <= is_write_d;
            bus.grant_id  <= grant_d;
            bus.readies   <= readies_d;
            bus.rdata     <= rdata_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_en    <= mem_en_d;
            bus.busy      <= busy_d;
        end
    end
endmodule
